uart_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_fifo.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART: register map, STATUS bit
// positions, FSM state encodings and the divisor floor.
package uart_pkg;

  // Word offsets selected by addr (d_addr[3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  // STATUS register bit positions
  localparam int ST_TXBUSY   = 0;
  localparam int ST_TXFULL   = 1;
  localparam int ST_RXAVAIL  = 2;
  localparam int ST_RXFULL   = 3;
  localparam int ST_OVERRUN  = 4;
  localparam int ST_FRAMEERR = 5;
  localparam int ST_TXDROP   = 6;

  // Smallest divisor the bit timers can work with (RX needs a mid-point)
  localparam logic [15:0] MIN_DIVISOR = 16'd4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Raise too-small divisor writes to the floor
  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < MIN_DIVISOR) ? MIN_DIVISOR : value;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO. The head entry is visible on rdata while
// the FIFO is non-empty; a pop advances to the next entry. A push into a
// full FIFO is accepted only when a pop happens on the same edge.
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_reg [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign rdata   = mem_reg[rd_ptr_reg];

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// Buffered UART on the CPU data bus: TX FIFO, programmable baud divisor,
// sticky error flags and a level interrupt. The receive path (synchroniser,
// RX FSM, RX FIFO) is built only when UART_RX_EN is defined.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DIVISOR    = 434,
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_BITS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  localparam logic [15:0] DIV_RESET = 16'(DIVISOR);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic wr_data, wr_status, wr_div;
  assign wr_data   = cs && we && (addr == REG_DATA);
  assign wr_status = cs && we && (addr == REG_STATUS);
  assign wr_div    = cs && we && (addr == REG_DIV);

  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[31:16]};

  // Baud divisor register
  logic [15:0] div_reg;

  // Divisor write with floor clamp
  always_ff @(posedge clk) begin
    if (reset) div_reg <= DIV_RESET;
    else if (wr_div) div_reg <= clamp_div(wdata[15:0]);
  end

  // ---------------- TX path ----------------
  logic                 tx_full, tx_empty, tx_pop, tx_drop, tx_bit_end, tx_busy;
  logic [DATA_BITS-1:0] tx_head;
  tx_state_t            tx_state_reg;
  logic [15:0]          tx_cnt_reg, tx_bit_div_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic [BIT_W-1:0]     tx_idx_reg;
  logic                 tx_reg;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .wdata (wdata[DATA_BITS-1:0]),
    .pop   (tx_pop),
    .rdata (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  assign tx_bit_end = (tx_cnt_reg == tx_bit_div_reg - 16'd1);
  assign tx_pop     = !tx_empty && ((tx_state_reg == TX_IDLE) ||
                                    ((tx_state_reg == TX_STOP) && tx_bit_end));
  assign tx_drop    = wr_data && tx_full && !tx_pop;
  assign tx_busy    = !tx_empty || (tx_state_reg != TX_IDLE);
  assign tx         = tx_reg;

  // TX FSM; the divisor is re-latched at every bit boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_reg   <= TX_IDLE;
      tx_reg         <= 1'b1;
      tx_cnt_reg     <= '0;
      tx_bit_div_reg <= DIV_RESET;
      tx_shift_reg   <= '0;
      tx_idx_reg     <= '0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          tx_cnt_reg <= '0;
          if (!tx_empty) begin
            tx_state_reg   <= TX_START;
            tx_reg         <= 1'b0;
            tx_shift_reg   <= tx_head;
            tx_bit_div_reg <= div_reg;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state_reg   <= TX_DATA;
            tx_cnt_reg     <= '0;
            tx_bit_div_reg <= div_reg;
            tx_reg         <= tx_shift_reg[0];
            tx_shift_reg   <= tx_shift_reg >> 1;
            tx_idx_reg     <= '0;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_reg     <= '0;
            tx_bit_div_reg <= div_reg;
            if (tx_idx_reg == LAST_BIT) begin
              tx_state_reg <= TX_STOP;
              tx_reg       <= 1'b1;
            end else begin
              tx_reg       <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_idx_reg   <= tx_idx_reg + 1'b1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_cnt_reg     <= '0;
            tx_bit_div_reg <= div_reg;
            if (!tx_empty) begin
              // Chain straight into the next start bit, no idle gap
              tx_state_reg <= TX_START;
              tx_reg       <= 1'b0;
              tx_shift_reg <= tx_head;
            end else begin
              tx_state_reg <= TX_IDLE;
              tx_reg       <= 1'b1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
          end
        end
        default: begin
          tx_state_reg <= TX_IDLE;
          tx_reg       <= 1'b1;
        end
      endcase
    end
  end

  // Sticky TXDROP; a same-cycle set beats the write-1-to-clear
  logic txdrop_reg;
  always_ff @(posedge clk) begin
    if (reset) txdrop_reg <= 1'b0;
    else txdrop_reg <= (txdrop_reg & ~(wr_status & wdata[ST_TXDROP])) | tx_drop;
  end

  // ---------------- RX path ----------------
  logic        rx_avail, rx_full_flag, overrun_reg, frameerr_reg;
  logic [31:0] rx_head_word;

`ifdef UART_RX_EN
  logic                 rx_full, rx_empty, rx_pop, rx_push, rx_stop_sample;
  logic                 set_overrun, set_frameerr, rx_s, rx_bit_end;
  logic [DATA_BITS-1:0] rx_head;
  logic [1:0]           rx_sync_reg;
  logic                 rx_prev_reg;
  rx_state_t            rx_state_reg;
  logic [15:0]          rx_cnt_reg, rx_bit_div_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic [BIT_W-1:0]     rx_idx_reg;

  // Two-flop synchroniser chain for the asynchronous rx pin
  for (genvar gi = 0; gi < 2; gi++) begin : g_rx_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (reset) rx_sync_reg[gi] <= 1'b1;
        else rx_sync_reg[gi] <= rx;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (reset) rx_sync_reg[gi] <= 1'b1;
        else rx_sync_reg[gi] <= rx_sync_reg[gi-1];
      end
    end
  end

  assign rx_s           = rx_sync_reg[1];
  assign rx_bit_end     = (rx_cnt_reg == rx_bit_div_reg - 16'd1);
  assign rx_stop_sample = (rx_state_reg == RX_STOP) && rx_bit_end;
  assign rx_push        = rx_stop_sample && rx_s;
  assign set_frameerr   = rx_stop_sample && !rx_s;
  assign rx_pop         = cs && re && (addr == REG_DATA) && !rx_empty;
  assign set_overrun    = rx_push && rx_full && !rx_pop;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .wdata (rx_shift_reg),
    .pop   (rx_pop),
    .rdata (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // RX FSM: start detect, mid-bit sampling, stop check
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_reg   <= RX_IDLE;
      rx_prev_reg    <= 1'b1;
      rx_cnt_reg     <= '0;
      rx_bit_div_reg <= DIV_RESET;
      rx_shift_reg   <= '0;
      rx_idx_reg     <= '0;
    end else begin
      rx_prev_reg <= rx_s;
      case (rx_state_reg)
        RX_IDLE: begin
          rx_cnt_reg     <= '0;
          rx_bit_div_reg <= div_reg;
          if (rx_prev_reg && !rx_s) rx_state_reg <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_reg == (rx_bit_div_reg >> 1) - 16'd1) begin
            rx_cnt_reg     <= '0;
            rx_bit_div_reg <= div_reg;
            rx_idx_reg     <= '0;
            rx_state_reg   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_cnt_reg     <= '0;
            rx_bit_div_reg <= div_reg;
            rx_shift_reg   <= {rx_s, rx_shift_reg[DATA_BITS-1:1]};
            if (rx_idx_reg == LAST_BIT) rx_state_reg <= RX_STOP;
            else rx_idx_reg <= rx_idx_reg + 1'b1;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_bit_end) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s) rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // Sticky RX error flags; set wins over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_reg  <= 1'b0;
      frameerr_reg <= 1'b0;
    end else begin
      overrun_reg  <= (overrun_reg & ~(wr_status & wdata[ST_OVERRUN])) | set_overrun;
      frameerr_reg <= (frameerr_reg & ~(wr_status & wdata[ST_FRAMEERR])) | set_frameerr;
    end
  end

  assign rx_avail     = !rx_empty;
  assign rx_full_flag = rx_full;
  assign rx_head_word = rx_empty ? 32'd0 : {{(32-DATA_BITS){1'b0}}, rx_head};
`else
  logic unused_rx;
  assign unused_rx    = &{1'b0, rx, re};
  assign rx_avail     = 1'b0;
  assign rx_full_flag = 1'b0;
  assign overrun_reg  = 1'b0;
  assign frameerr_reg = 1'b0;
  assign rx_head_word = 32'd0;
`endif

  // STATUS word assembly
  logic [31:0] status_word;
  always_comb begin
    status_word              = '0;
    status_word[ST_TXBUSY]   = tx_busy;
    status_word[ST_TXFULL]   = tx_full;
    status_word[ST_RXAVAIL]  = rx_avail;
    status_word[ST_RXFULL]   = rx_full_flag;
    status_word[ST_OVERRUN]  = overrun_reg;
    status_word[ST_FRAMEERR] = frameerr_reg;
    status_word[ST_TXDROP]   = txdrop_reg;
  end

  // Combinational read mux
  always_comb begin
    rdata = '0;
    case (addr)
      REG_DATA:   rdata = rx_head_word;
      REG_STATUS: rdata = status_word;
      REG_DIV:    rdata = {16'd0, div_reg};
      default:    rdata = '0;
    endcase
  end

  // Registered interrupt level
  logic irq_reg;
  always_ff @(posedge clk) begin
    if (reset) irq_reg <= 1'b0;
    else irq_reg <= rx_avail | overrun_reg | frameerr_reg | txdrop_reg;
  end
  assign irq = irq_reg;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: register reset values, TX framing and
// chaining, TX FIFO overflow, reset abort, and (with UART_RX_EN) receive,
// overrun, framing error and glitch rejection.
module tb_uart_fifo;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_DIV  = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, we = 1'b0, re = 1'b0, rx = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        tx, irq;

  int n_tests = 0;
  int n_fail  = 0;

  uart_fifo #(.DIVISOR(434), .DEPTH_LOG2(4), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx(tx), .rx(rx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) begin
      $display("[TB] %s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic pop, output logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; re = pop; addr = a;
    #1 v = rdata;
    @(negedge clk);
    cs = 1'b0; re = 1'b0;
  endtask

  // Serial frame at 8 clocks per bit, chosen stop-bit level
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
    rx = stop_bit;
    repeat (8) @(negedge clk);
    rx = 1'b1;
  endtask

  logic [31:0] v;
  logic [19:0] samp;
  bit          found;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd(A_STAT, 1'b0, v); check("reset_status", v, 32'h0000_0000);
    rd(A_DIV,  1'b0, v); check("reset_div", v, 32'd434);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);

    // Divisor clamp and programming
    wr(A_DIV, 32'd2);
    rd(A_DIV, 1'b0, v); check("div_clamp", v, 32'd4);
    wr(A_DIV, 32'd8);
    rd(A_DIV, 1'b0, v); check("div_set8", v, 32'd8);

    // Two chained characters
    wr(A_DATA, 32'h55);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (tx == 1'b0) found = 1'b1;
    end
    check("tx_first_start", 32'(tx), 32'd0);
    fork
      wr(A_DATA, 32'hA3);
      begin
        repeat (4) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
          samp[k] = tx;
          if (k < 19) repeat (8) @(negedge clk);
        end
      end
    join
    check("tx_frame_55", 32'(samp[9:0]), 32'({1'b1, 8'h55, 1'b0}));
    check("tx_frame_a3", 32'(samp[19:10]), 32'({1'b1, 8'hA3, 1'b0}));
    rd(A_STAT, 1'b0, v); check("txbusy_in_stop", v, 32'h0000_0001);
    repeat (4) @(negedge clk);
    rd(A_STAT, 1'b0, v); check("txbusy_cleared", v, 32'h0000_0000);

    // TX FIFO overflow: one pop has happened, so 17 fit and the 18th drops
    for (int i = 0; i < 17; i++) wr(A_DATA, 32'(8'h10 + i));
    rd(A_STAT, 1'b0, v); check("tx_full_17", v, 32'h0000_0003);
    check("irq_no_drop", 32'(irq), 32'd0);
    wr(A_DATA, 32'hEE);
    rd(A_STAT, 1'b0, v); check("txdrop_set", v, 32'h0000_0043);
    check("irq_txdrop", 32'(irq), 32'd1);
    wr(A_STAT, 32'h40);
    rd(A_STAT, 1'b0, v); check("txdrop_clear", v, 32'h0000_0003);
    check("irq_cleared", 32'(irq), 32'd0);

    // Reset in the middle of a character
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (tx == 1'b0) found = 1'b1;
    end
    check("tx_low_before_reset", 32'(tx), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 check("tx_high_after_reset", 32'(tx), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    rd(A_STAT, 1'b0, v); check("status_after_reset", v, 32'h0000_0000);
    rd(A_DIV,  1'b0, v); check("div_after_reset", v, 32'd434);
    repeat (20) @(negedge clk);
    check("tx_idle_after_reset", 32'(tx), 32'd1);

    wr(A_DIV, 32'd8);
`ifdef UART_RX_EN
    // Single received byte
    send_rx(8'h3C, 1'b1);
    rd(A_STAT, 1'b0, v); check("rxavail_set", v, 32'h0000_0004);
    check("irq_rxavail", 32'(irq), 32'd1);
    rd(A_DATA, 1'b1, v); check("rx_data_3c", v, 32'h3C);
    rd(A_STAT, 1'b0, v); check("rxavail_clear", v, 32'h0000_0000);
    check("irq_rx_idle", 32'(irq), 32'd0);

    // Seventeen bytes without reads: last one overruns
    for (int i = 0; i < 17; i++) send_rx(8'(i), 1'b1);
    rd(A_STAT, 1'b0, v); check("rx_overrun", v, 32'h0000_001C);
    rd(A_DATA, 1'b1, v); check("rx_head_00", v, 32'h00);
    rd(A_STAT, 1'b0, v); check("rx_after_pop", v, 32'h0000_0014);

    // Bad stop bit, then a short glitch
    send_rx(8'h77, 1'b0);
    repeat (4) @(negedge clk);
    rd(A_STAT, 1'b0, v); check("rx_frameerr", v, 32'h0000_0034);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    rd(A_STAT, 1'b0, v); check("rx_glitch_ignored", v, 32'h0000_0034);

    for (int i = 1; i < 16; i++) begin
      rd(A_DATA, 1'b1, v); check($sformatf("rx_drain_%0d", i), v, 32'(i));
    end
    rd(A_DATA, 1'b1, v); check("rx_empty_read", v, 32'h0);
    rd(A_STAT, 1'b0, v); check("rx_flags_only", v, 32'h0000_0030);
    wr(A_STAT, 32'h30);
    rd(A_STAT, 1'b0, v); check("rx_flags_cleared", v, 32'h0000_0000);
    check("irq_final", 32'(irq), 32'd0);
`else
    // Receive logic absent: rx activity must be invisible
    send_rx(8'h3C, 1'b1);
    rd(A_STAT, 1'b0, v); check("norx_status", v, 32'h0000_0000);
    rd(A_DATA, 1'b1, v); check("norx_data", v, 32'h0);
    check("norx_irq", 32'(irq), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
